// File: rtl/branch_predictor_pkg.sv
// Shared widths and 2-bit counter encodings for the branch predictor slice.
package branch_predictor_pkg;

    localparam int DATA_W          = 32;
    localparam int ROB_ENTRY_W     = 4;
    localparam int ROB_ENTRIES     = 1 << ROB_ENTRY_W;
    localparam int BHT_ENTRIES_DEF = 16;
    localparam int BHT_IDX_W_DEF   = 4;
    localparam int STAT_W          = 32;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

endpackage : branch_predictor_pkg

// File: rtl/branch_predictor_if.sv
// Decoder / branch-ALU / ROB side bundle of the branch predictor.
interface branch_predictor_if;
    import branch_predictor_pkg::*;

    logic                   pred_req;
    logic [DATA_W-1:0]      pred_pc;
    logic [ROB_ENTRY_W-1:0] pred_rob_in;
    logic                   pred_valid;
    logic                   pred_taken;
    logic [ROB_ENTRY_W-1:0] pred_rob_out;
    logic                   res_valid;
    logic [ROB_ENTRY_W-1:0] res_rob_index;
    logic [1:0]             res_result;
    logic                   flush;
    logic                   mispred;
    logic [ROB_ENTRY_W-1:0] mispred_rob_index;
    logic [STAT_W-1:0]      stat_branches;
    logic [STAT_W-1:0]      stat_mispredicts;

    modport master (
        output pred_req, pred_pc, pred_rob_in,
        output res_valid, res_rob_index, res_result, flush,
        input  pred_valid, pred_taken, pred_rob_out,
        input  mispred, mispred_rob_index, stat_branches, stat_mispredicts
    );

    modport slave (
        input  pred_req, pred_pc, pred_rob_in,
        input  res_valid, res_rob_index, res_result, flush,
        output pred_valid, pred_taken, pred_rob_out,
        output mispred, mispred_rob_index, stat_branches, stat_mispredicts
    );

endinterface : branch_predictor_if

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] state_i,
    input  logic       taken_i,
    output logic [1:0] state_o
);

    always_comb begin
        state_o = state_i;
        if (taken_i) begin
            if (state_i != CTR_ST) state_o = state_i + 2'd1;
        end else begin
            if (state_i != CTR_SNT) state_o = state_i - 2'd1;
        end
    end

endmodule : sat_counter2

// File: rtl/branch_predictor.sv
// Bimodal branch predictor with per-ROB-slot pending table and mispredict pulse.
// Optional statistics counters are built only when BRA_PRED_STATS_EN is defined.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BHT_ENTRIES = BHT_ENTRIES_DEF,
    parameter int BHT_IDX_W   = BHT_IDX_W_DEF
)
(
    input  logic              clk,
    input  logic              rst,
    branch_predictor_if.slave bp
);

    typedef struct packed {
        logic                 valid;
        logic [BHT_IDX_W-1:0] bht_idx;
        logic                 pred;
    } pend_t;

    logic [1:0]             bht_q [BHT_ENTRIES];
    pend_t                  pend_q [ROB_ENTRIES];
    logic                   pred_valid_q;
    logic                   pred_taken_q;
    logic [ROB_ENTRY_W-1:0] pred_rob_q;
    logic                   mispred_q;
    logic [ROB_ENTRY_W-1:0] mispred_idx_q;

    logic [BHT_IDX_W-1:0]   lookup_idx;
    pend_t                  res_entry;
    logic                   res_hit;
    logic                   res_wrong;
    logic                   alloc;
    logic [1:0]             ctr_cur;
    logic [1:0]             ctr_d;

    assign lookup_idx = bp.pred_pc[BHT_IDX_W+1:2];
    assign res_entry  = pend_q[bp.res_rob_index];
    // A flush kills both the resolve and the allocation of its cycle.
    assign res_hit    = bp.res_valid & res_entry.valid & ~bp.flush;
    assign res_wrong  = bp.res_result[1] ^ bp.res_result[0];
    assign alloc      = bp.pred_req & ~bp.flush;
    assign ctr_cur    = bht_q[res_entry.bht_idx];

    sat_counter2 u_sat (
        .state_i (ctr_cur),
        .taken_i (bp.res_result[0]),
        .state_o (ctr_d)
    );

    // NOTE: the counter table is reset element by element so every entry starts weakly not-taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CTR_WNT;
        end else if (res_hit) begin
            bht_q[res_entry.bht_idx] <= ctr_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ROB_ENTRIES; i++) pend_q[i] <= '0;
        end else if (bp.flush) begin
            for (int i = 0; i < ROB_ENTRIES; i++) pend_q[i].valid <= 1'b0;
        end else begin
            if (res_hit) pend_q[bp.res_rob_index].valid <= 1'b0;
            // NOTE: the later non-blocking write wins, so an allocation overwrites a same-slot resolve clear.
            if (alloc) begin
                pend_q[bp.pred_rob_in] <= '{valid: 1'b1, bht_idx: lookup_idx,
                                            pred: bht_q[lookup_idx][1]};
            end
        end
    end

    // Lookups read the pre-update counter because the table is written only at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_rob_q    <= '0;
            mispred_q     <= 1'b0;
            mispred_idx_q <= '0;
        end else begin
            pred_valid_q <= alloc;
            if (alloc) begin
                pred_taken_q <= bht_q[lookup_idx][1];
                pred_rob_q   <= bp.pred_rob_in;
            end
            mispred_q <= res_hit & res_wrong;
            if (res_hit && res_wrong) mispred_idx_q <= bp.res_rob_index;
        end
    end

    assign bp.pred_valid        = pred_valid_q;
    assign bp.pred_taken        = pred_taken_q;
    assign bp.pred_rob_out      = pred_rob_q;
    assign bp.mispred           = mispred_q;
    assign bp.mispred_rob_index = mispred_idx_q;

`ifdef BRA_PRED_STATS_EN
    logic [STAT_W-1:0] stat_br_q;
    logic [STAT_W-1:0] stat_mp_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else if (res_hit) begin
            stat_br_q <= stat_br_q + 32'd1;
            if (res_wrong) stat_mp_q <= stat_mp_q + 32'd1;
        end
    end

    assign bp.stat_branches    = stat_br_q;
    assign bp.stat_mispredicts = stat_mp_q;
`else
    assign bp.stat_branches    = '0;
    assign bp.stat_mispredicts = '0;
`endif

    logic unused_bits;
    assign unused_bits = ^{bp.pred_pc[DATA_W-1:BHT_IDX_W+2], bp.pred_pc[1:0], res_entry.pred};

endmodule : branch_predictor

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (both BRA_PRED_STATS_EN builds).
module tb_branch_predictor;
    import branch_predictor_pkg::*;

`ifdef BRA_PRED_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    branch_predictor_if bp_if ();

    branch_predictor dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bp_if.pred_req      = 1'b0;
        bp_if.pred_pc       = '0;
        bp_if.pred_rob_in   = '0;
        bp_if.res_valid     = 1'b0;
        bp_if.res_rob_index = '0;
        bp_if.res_result    = 2'b00;
        bp_if.flush         = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic [3:0] rob);
        bp_if.pred_req    = 1'b1;
        bp_if.pred_pc     = pc;
        bp_if.pred_rob_in = rob;
    endtask

    task automatic resolve(input logic [3:0] rob, input logic [1:0] res);
        bp_if.res_valid     = 1'b1;
        bp_if.res_rob_index = rob;
        bp_if.res_result    = res;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic check_stats(input string tag, input int br, input int mp);
        check({tag, "_branches"}, bp_if.stat_branches, STATS_ON ? br : 0);
        check({tag, "_mispredicts"}, bp_if.stat_mispredicts, STATS_ON ? mp : 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        clear_inputs();
        #2;
        check("rst_pred_valid", bp_if.pred_valid, 0);
        check("rst_pred_taken", bp_if.pred_taken, 0);
        check("rst_pred_rob", bp_if.pred_rob_out, 0);
        check("rst_mispred", bp_if.mispred, 0);
        check("rst_mispred_idx", bp_if.mispred_rob_index, 0);
        check_stats("rst", 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // First lookup after reset sees a weakly not-taken counter.
        lookup(32'h100, 4'd3); tick();
        check("first_valid", bp_if.pred_valid, 1);
        check("first_taken", bp_if.pred_taken, 0);
        check("first_rob", bp_if.pred_rob_out, 3);
        tick();
        check("idle_valid", bp_if.pred_valid, 0);
        check("idle_taken_hold", bp_if.pred_taken, 0);
        check("idle_rob_hold", bp_if.pred_rob_out, 3);

        // Training: two actual-taken resolves drive idx 0 from 01 to 11.
        resolve(4'd3, 2'b01); tick();
        check("train1_mispred", bp_if.mispred, 1);
        check("train1_idx", bp_if.mispred_rob_index, 3);
        tick();
        check("train1_pulse_end", bp_if.mispred, 0);
        lookup(32'h100, 4'd4); tick();
        check("train_mid_taken", bp_if.pred_taken, 1);
        resolve(4'd4, 2'b01); tick();
        check("train2_idx", bp_if.mispred_rob_index, 4);
        lookup(32'h100, 4'd6); tick();
        check("trained_taken", bp_if.pred_taken, 1);

        // Mispredict on slot 5 (idx 1, 01 -> 00).
        lookup(32'h104, 4'd5); tick();
        check("mp_alloc_taken", bp_if.pred_taken, 0);
        check("mp_alloc_rob", bp_if.pred_rob_out, 5);
        resolve(4'd5, 2'b10); tick();
        check("mp_pulse", bp_if.mispred, 1);
        check("mp_idx", bp_if.mispred_rob_index, 5);
        check_stats("mp", 3, 3);
        tick();
        check("mp_pulse_end", bp_if.mispred, 0);

        resolve(4'd6, 2'b11); tick();
        check("correct_no_mp", bp_if.mispred, 0);
        resolve(4'd5, 2'b10); tick();
        check("stale_no_mp", bp_if.mispred, 0);
        check_stats("stale", 4, 3);

        // Saturation at 00: three not-taken resolves must not underflow.
        for (int i = 0; i < 3; i++) begin
            lookup(32'h104, 4'd7); tick();
            check("sat_taken", bp_if.pred_taken, 0);
            resolve(4'd7, 2'b00); tick();
            check("sat_no_mp", bp_if.mispred, 0);
        end
        lookup(32'h104, 4'd7); tick();
        resolve(4'd7, 2'b01); tick();
        check("sat_up_mp", bp_if.mispred, 1);
        lookup(32'h104, 4'd8); tick();
        check("sat_held_00", bp_if.pred_taken, 0);

        // Same-cycle lookup and resolve on idx 1 (counter 01, actual taken).
        lookup(32'h104, 4'd9); resolve(4'd8, 2'b01); tick();
        check("same_cyc_taken", bp_if.pred_taken, 0);
        check("same_cyc_mp_idx", bp_if.mispred_rob_index, 8);
        lookup(32'h104, 4'd10); tick();
        check("same_cyc_after", bp_if.pred_taken, 1);

        // Same-slot resolve and allocation: resolve first, then overwrite.
        resolve(4'd10, 2'b10); lookup(32'h108, 4'd10); tick();
        check("slot_ovw_mp", bp_if.mispred, 1);
        check("slot_ovw_taken", bp_if.pred_taken, 0);
        resolve(4'd10, 2'b01); tick();
        check("slot_new_mp", bp_if.mispred, 1);
        check("slot_new_idx", bp_if.mispred_rob_index, 10);
        lookup(32'h108, 4'd13); tick();
        check("slot_new_trained", bp_if.pred_taken, 1);
        lookup(32'h104, 4'd14); tick();
        check("slot_old_trained", bp_if.pred_taken, 0);
        check_stats("pre_flush", 11, 7);

        // Flush clears pending entries and suppresses the same-cycle allocation.
        lookup(32'h10C, 4'd1); tick();
        lookup(32'h10C, 4'd2); tick();
        lookup(32'h10C, 4'd11); bp_if.flush = 1'b1; tick();
        check("flush_valid", bp_if.pred_valid, 0);
        check("flush_rob_hold", bp_if.pred_rob_out, 2);
        resolve(4'd1, 2'b01); tick();
        check("flush_slot1", bp_if.mispred, 0);
        resolve(4'd2, 2'b01); tick();
        check("flush_slot2", bp_if.mispred, 0);
        resolve(4'd11, 2'b01); tick();
        check("flush_slot11", bp_if.mispred, 0);
        resolve(4'd9, 2'b01); tick();
        check("flush_slot9", bp_if.mispred, 0);
        lookup(32'h10C, 4'd1); tick();
        check("flush_ctr_kept", bp_if.pred_taken, 0);
        check_stats("post_flush", 11, 7);

        // Reset in the middle of operation.
        lookup(32'h100, 4'd12); tick();
        check("pre_rst_taken", bp_if.pred_taken, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", bp_if.pred_valid, 0);
        check("mid_rst_taken", bp_if.pred_taken, 0);
        check("mid_rst_rob", bp_if.pred_rob_out, 0);
        check_stats("mid_rst", 0, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        resolve(4'd12, 2'b01); tick();
        check("post_rst_no_mp", bp_if.mispred, 0);
        lookup(32'h100, 4'd12); tick();
        check("post_rst_valid", bp_if.pred_valid, 1);
        check("post_rst_taken", bp_if.pred_taken, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_branch_predictor

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter BHT_ENTRIES, default 16, number of 2-bit counters (power of two).
REQ-002 SHALL have parameter BHT_IDX_W, default 4, log2(BHT_ENTRIES).
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port pred_req, input, 1, decoder requests a prediction for a branch.
REQ-006 SHALL have port pred_pc, input, `Data_Width, branch PC.
REQ-007 SHALL have port pred_rob_in, input, `ROB_Entry_Width, ROB slot allocated to the branch.
REQ-008 SHALL have port pred_valid, output, 1, prediction available (feeds Bra_Pre field).
REQ-009 SHALL have port pred_taken, output, 1, predicted direction.
REQ-010 SHALL have port pred_rob_out, output, `ROB_Entry_Width, echo of pred_rob_in.
REQ-011 SHALL have port res_valid, input, 1, branch result from branch ALU.
REQ-012 SHALL have port res_rob_index, input, `ROB_Entry_Width, ROB slot of resolved branch.
REQ-013 SHALL have port res_result, input, 2, {predicted, actual}.
REQ-014 SHALL have port flush, input, 1, pipeline flush from ROB.
REQ-015 SHALL have port mispred, output, 1, one-cycle mispredict pulse.
REQ-016 SHALL have port mispred_rob_index, output, `ROB_Entry_Width, slot of mispredicted branch.
REQ-017 SHALL have ports stat_branches and stat_mispredicts, output, 32 each, statistics counters.

Function
REQ-018 SHALL index the BHT with pred_pc[BHT_IDX_W+1:2].
REQ-019 SHALL register the response: pred_req in cycle N gives pred_valid=1 in N+1, with pred_taken = counter[1] as it was in cycle N.
REQ-020 SHALL record, on pred_req, a pending entry {valid=1, bht_idx, pred} at slot pred_rob_in; there is one pending entry per ROB slot.
REQ-021 SHALL, on res_valid with a valid pending entry, update the counter: actual=1 increments, saturating at 2'b11; actual=0 decrements, saturating at 2'b00. It SHALL then clear the entry.
REQ-022 SHALL ignore res_valid when the pending entry is invalid: no update, no pulse, no statistics change.
REQ-023 SHALL assert mispred for exactly one cycle, in N+1 after a valid resolve in N with res_result[1] != res_result[0], and drive mispred_rob_index = res_rob_index in that cycle.
REQ-024 SHALL, when the resolve updates the same counter that a lookup reads in the same cycle, give the lookup the pre-update value.
REQ-025 SHALL, when a resolve and an allocation target the same ROB slot in the same cycle, process the resolve first and then let the allocation overwrite the entry.
REQ-026 SHALL, on flush, clear all pending valid bits, suppress any same-cycle allocation, and force pred_valid=0 and mispred=0 in the next cycle; BHT counters are retained.
REQ-027 SHALL leave pred_taken and pred_rob_out holding their last values while pred_valid=0.

Reset
REQ-028 SHALL asynchronously set on rst=0: all counters to 2'b01 (weakly not-taken), all pending entries invalid, pred_valid=0, pred_taken=0, pred_rob_out=0, mispred=0, mispred_rob_index=0, stat counters=0.
REQ-029 SHALL discard all in-flight lookups and resolves when reset is asserted mid-operation; the first prediction after release reflects reset counters.

Configuration
REQ-030 SHALL, with BRA_PRED_STATS_EN defined, increment stat_branches on each valid resolve and stat_mispredicts on each mispredict; both wrap at 2^32.
REQ-031 SHALL, without BRA_PRED_STATS_EN, tie stat_branches and stat_mispredicts to 0 and omit the counter logic.

Structure
REQ-032 SHALL put `BHT_Entries, `BHT_Idx_Width and the counter encodings (SNT=00, WNT=01, WT=10, ST=11) in defines.v alongside `ROB_Entry_Width and `Data_Width.
REQ-033 SHALL implement the saturating update as one sub-module, sat_counter2 (2-bit state in, direction in, 2-bit next state out).

Verification
REQ-034 SHALL cover reset: after rst pulse, pred_req pc=0x100, rob=3 -> next cycle pred_valid=1, pred_taken=0, pred_rob_out=3.
REQ-035 SHALL cover training: two resolves of pc=0x100 with result=2'b01 -> counter=11; next lookup gives pred_taken=1.
REQ-036 SHALL cover mispredict: pending slot 5, res_result=2'b10 -> mispred=1 for one cycle, mispred_rob_index=5; stat_mispredicts=1 when BRA_PRED_STATS_EN is defined.
REQ-037 SHALL cover saturation: counter at 00 with three not-taken resolves -> counter stays 00 and no mispred when pred=0.
REQ-038 SHALL cover flush: allocate slots 1 and 2, then flush with a same-cycle pred_req -> pred_valid=0 next cycle; later resolves of slots 1 and 2 are ignored.
REQ-039 SHALL cover the same-cycle case: lookup and resolve on the same index, counter 01, actual=1 -> lookup returns 0 and a lookup one cycle later returns 1.
